coproc_block_sequencer: RTL and testbench

Control stage that drives the coprocessor's block memory. It watches the config word (address 0) for a start request, streams N 4-word data blocks out of memory to the compute unit, and writes each result block back in place. It also maintains the status word (address 1). The block sits between the memory (`memory`) and the compute datapath and owns every memory read/write/status-write strobe.

---
 rtl/coproc_pkg.sv | 44 ++++
 rtl/coproc_block_sequencer_watchdog.sv | 35 +++
 rtl/coproc_block_sequencer.sv | 164 ++++++++++++++++
 tb/tb_coproc_block_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coproc_pkg.sv
// Shared definitions for the coprocessor block sequencer: config/status field
// positions, data region base, FSM state encoding and a status-word builder.
package coproc_pkg;

    localparam int unsigned CFG_START_BIT = 0;
    localparam int unsigned CFG_N_LSB     = 8;

    localparam int unsigned STS_BUSY_BIT  = 0;
    localparam int unsigned STS_DONE_BIT  = 1;
    localparam int unsigned STS_ERR_BIT   = 2;
    localparam int unsigned STS_CNT_LSB   = 8;

    localparam int unsigned DATA_BASE     = 4;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_READ   = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_SEND   = 3'd3;
    localparam logic [2:0] S_RESULT = 3'd4;
    localparam logic [2:0] S_WRITE  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    typedef enum logic [2:0] {
        SEQ_IDLE   = S_IDLE,
        SEQ_READ   = S_READ,
        SEQ_WAIT   = S_WAIT,
        SEQ_SEND   = S_SEND,
        SEQ_RESULT = S_RESULT,
        SEQ_WRITE  = S_WRITE,
        SEQ_DONE   = S_DONE
    } seq_state_e;

    function automatic logic [15:0] make_status(input logic [7:0] count, input logic busy,
                                                input logic done, input logic err);
        logic [15:0] s;
        s                      = '0;
        s[STS_BUSY_BIT]        = busy;
        s[STS_DONE_BIT]        = done;
        s[STS_ERR_BIT]         = err;
        s[STS_CNT_LSB +: 8]    = count;
        return s;
    endfunction

endpackage

// File: rtl/coproc_block_sequencer_watchdog.sv
// Handshake watchdog for the block sequencer: counts while enabled, clears on
// request, and flags expiry on the cycle the count reaches the limit.
module seq_watchdog #(
    parameter int limit = 256
) (
    input  logic in_clk,
    input  logic in_reset,
    input  logic in_en,
    input  logic in_clr,
    output logic out_expired
);
    localparam int CNT_W = $clog2(limit + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (in_clr) begin
            cnt_d = '0;
        end else if (in_en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign out_expired = in_en && !in_clr && (cnt_q == CNT_W'(limit - 1));

    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/coproc_block_sequencer.sv
// Block sequencer: streams N 4-cell blocks from memory through compute and writes
// results back in place, maintaining the status word. SEQ_TIMEOUT_EN adds a watchdog.
module coproc_block_sequencer
    import coproc_pkg::*;
#(
    parameter int size           = 1024,
    parameter int blocks         = 4,
    parameter int log_size       = 10,
    parameter int cell_width     = 32,
    parameter int width          = blocks * cell_width,
    parameter int timeout_cycles = 256
) (
    input  logic                  in_clk,
    input  logic                  in_reset,
    input  logic [cell_width-1:0] in_config,
    output logic [log_size-1:0]   out_address,
    output logic                  out_read_en,
    output logic                  out_write_en,
    output logic [width-1:0]      out_data,
    input  logic [width-1:0]      in_data,
    output logic [cell_width-1:0] out_status,
    output logic                  out_write_status_en,
    output logic                  out_blk_valid,
    input  logic                  in_blk_ready,
    output logic [width-1:0]      out_blk_data,
    input  logic                  in_res_valid,
    output logic                  out_res_ready,
    input  logic [width-1:0]      in_res_data
);
    seq_state_e            state_q, state_d;
    logic                  cfg_q, cfg_d;
    logic                  start_q, start_d;
    logic [7:0]            n_q, n_d;
    logic [7:0]            k_q, k_d;
    logic [width-1:0]      operand_q, operand_d;
    logic [width-1:0]      result_q, result_d;
    logic [cell_width-1:0] status_q, status_d;
    logic                  status_we_q, status_we_d;

    logic [7:0]            cfg_n;
    logic [31:0]           cfg_need;
    logic                  cfg_in_range;
    logic [log_size-1:0]   blk_addr;

    assign cfg_n        = in_config[CFG_N_LSB +: 8];
    assign cfg_need     = (32'(cfg_n) + 32'd1) * 32'(blocks);
    assign cfg_in_range = cfg_need <= 32'(size);
    assign blk_addr     = log_size'(32'(DATA_BASE) + 32'(blocks) * 32'(k_q));

`ifdef SEQ_TIMEOUT_EN
    logic wd_active, wd_clear, wd_expired;

    assign wd_active = (state_q == SEQ_SEND) || (state_q == SEQ_RESULT);
    assign wd_clear  = !wd_active
                     || ((state_q == SEQ_SEND) && in_blk_ready)
                     || ((state_q == SEQ_RESULT) && in_res_valid);

    seq_watchdog #(.limit(timeout_cycles)) u_watchdog (
        .in_clk     (in_clk),
        .in_reset   (in_reset),
        .in_en      (wd_active),
        .in_clr     (wd_clear),
        .out_expired(wd_expired)
    );
`endif

    always_comb begin
        state_d     = state_q;
        cfg_d       = in_config[CFG_START_BIT];
        start_d     = in_config[CFG_START_BIT] & ~cfg_q;
        n_d         = n_q;
        k_d         = k_q;
        operand_d   = operand_q;
        result_d    = result_q;
        status_d    = status_q;
        status_we_d = 1'b0;

        // Status writes are registered, so each one appears in the cycle after its transition.
        case (state_q)
            SEQ_IDLE: begin
                if (start_q) begin
                    status_we_d = 1'b1;
                    if (!cfg_in_range) begin
                        status_d = cell_width'(make_status(8'd0, 1'b0, 1'b1, 1'b1));
                    end else begin
                        n_d      = cfg_n;
                        k_d      = 8'd0;
                        status_d = cell_width'(make_status(8'd0, 1'b1, 1'b0, 1'b0));
                        state_d  = (cfg_n == 8'd0) ? SEQ_DONE : SEQ_READ;
                    end
                end
            end
            SEQ_READ: state_d = SEQ_WAIT;
            SEQ_WAIT: begin
                operand_d = in_data;
                state_d   = SEQ_SEND;
            end
            SEQ_SEND: begin
                if (in_blk_ready) state_d = SEQ_RESULT;
            end
            SEQ_RESULT: begin
                if (in_res_valid) begin
                    result_d    = in_res_data;
                    status_d    = cell_width'(make_status(k_q + 8'd1, 1'b1, 1'b0, 1'b0));
                    status_we_d = 1'b1;
                    state_d     = SEQ_WRITE;
                end
            end
            SEQ_WRITE: begin
                k_d     = k_q + 8'd1;
                state_d = (k_q + 8'd1 == n_q) ? SEQ_DONE : SEQ_READ;
            end
            SEQ_DONE: begin
                status_d    = cell_width'(make_status(n_q, 1'b0, 1'b1, 1'b0));
                status_we_d = 1'b1;
                state_d     = SEQ_IDLE;
            end
            default: state_d = SEQ_IDLE;
        endcase

`ifdef SEQ_TIMEOUT_EN
        if (wd_expired) begin
            status_d    = cell_width'(make_status(k_q, 1'b0, 1'b1, 1'b1));
            status_we_d = 1'b1;
            state_d     = SEQ_IDLE;
        end
`endif
    end

    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            state_q     <= SEQ_IDLE;
            cfg_q       <= 1'b0;
            start_q     <= 1'b0;
            n_q         <= '0;
            k_q         <= '0;
            operand_q   <= '0;
            result_q    <= '0;
            status_q    <= '0;
            status_we_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            start_q     <= start_d;
            n_q         <= n_d;
            k_q         <= k_d;
            operand_q   <= operand_d;
            result_q    <= result_d;
            status_q    <= status_d;
            status_we_q <= status_we_d;
        end
    end

    assign out_read_en         = (state_q == SEQ_READ);
    assign out_write_en        = (state_q == SEQ_WRITE);
    assign out_address         = (out_read_en || out_write_en) ? blk_addr : '0;
    assign out_data            = result_q;
    assign out_blk_valid       = (state_q == SEQ_SEND);
    assign out_blk_data        = operand_q;
    assign out_res_ready       = (state_q == SEQ_RESULT);
    assign out_status          = status_q;
    assign out_write_status_en = status_we_q;

endmodule

// File: tb/tb_coproc_block_sequencer.sv
// Self-checking bench for coproc_block_sequencer: memory and compute models plus a
// rule-level reference of the expected read/write/status traffic. Timeout case needs SEQ_TIMEOUT_EN.
module tb_coproc_block_sequencer;
    localparam int SIZE = 256;
    localparam int LOG  = 8;
    localparam int CW   = 32;
    localparam int BLK  = 4;
    localparam int W    = BLK * CW;
    localparam int TMO  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] cfg_word;
    logic [LOG-1:0] address;
    logic          read_en, write_en;
    logic [W-1:0]  wdata;
    logic [W-1:0]  rdata = '0;
    logic [CW-1:0] status;
    logic          status_en;
    logic          blk_valid;
    logic          blk_ready = 1'b0;
    logic [W-1:0]  blk_data;
    logic          res_valid = 1'b0;
    logic          res_ready;
    logic [W-1:0]  res_data = '0;

    coproc_block_sequencer #(
        .size(SIZE), .blocks(BLK), .log_size(LOG), .cell_width(CW), .width(W), .timeout_cycles(TMO)
    ) dut (
        .in_clk(clk), .in_reset(rst), .in_config(cfg_word),
        .out_address(address), .out_read_en(read_en), .out_write_en(write_en),
        .out_data(wdata), .in_data(rdata),
        .out_status(status), .out_write_status_en(status_en),
        .out_blk_valid(blk_valid), .in_blk_ready(blk_ready), .out_blk_data(blk_data),
        .in_res_valid(res_valid), .out_res_ready(res_ready), .in_res_data(res_data)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_miss = 0;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory model, traffic logs and compute model
    logic [CW-1:0] mem  [SIZE];
    logic [CW-1:0] orig [SIZE];
    int            cyc = 0;
    int            cfg_cyc = 0;
    int            rd_addr_q[$];
    int            rd_cyc_q[$];
    int            wr_addr_q[$];
    logic [CW-1:0] st_q[$];
    int            st_cyc_q[$];
    int            res_entry_cyc = 0;
    int            blk_cnt = 0;
    int            overlap = 0;
    logic          res_ready_prev = 1'b0;
    int            blk_mode = 0;
    int            res_mode = 0;
    logic [W-1:0]  res_pend[$];

    function automatic logic [W-1:0] inc_cells(input logic [W-1:0] x);
        logic [W-1:0] r;
        for (int i = 0; i < BLK; i++) r[i*CW +: CW] = x[i*CW +: CW] + 32'd1;
        return r;
    endfunction

    function automatic logic [CW-1:0] mk_status(input int cnt, input bit busy, input bit done, input bit err);
        return {16'h0, 8'(cnt), 5'b0, err, done, busy};
    endfunction

    always @(posedge clk) begin
        if (read_en) begin
            for (int i = 0; i < BLK; i++) rdata[i*CW +: CW] <= mem[int'(address) + i];
            rd_addr_q.push_back(int'(address));
            rd_cyc_q.push_back(cyc);
        end
        if (write_en) begin
            for (int i = 0; i < BLK; i++) mem[int'(address) + i] = wdata[i*CW +: CW];
            wr_addr_q.push_back(int'(address));
        end
        if (status_en) begin
            mem[1] = status;
            st_q.push_back(status);
            st_cyc_q.push_back(cyc);
        end
        if (read_en && write_en) overlap++;
        if (res_ready && !res_ready_prev) res_entry_cyc = cyc;
        res_ready_prev = res_ready;
        if (blk_valid && blk_ready) begin
            blk_cnt++;
            res_pend.push_back(inc_cells(blk_data));
        end
        if (res_valid && res_ready && res_pend.size() > 0) res_pend.delete(0);
        cyc++;
    end

    always @(negedge clk) begin
        case (blk_mode)
            0:       blk_ready = 1'b1;
            1:       blk_ready = ($urandom_range(0, 2) != 0);
            default: blk_ready = 1'b0;
        endcase
        if (res_pend.size() == 0) res_valid = 1'b0;
        else if (!res_valid) res_valid = (res_mode == 0) || (res_mode == 1 && $urandom_range(0, 2) == 0);
        res_data = (res_pend.size() > 0) ? res_pend[0] : '0;
    end

    task automatic clear_logs();
        rd_addr_q.delete();
        rd_cyc_q.delete();
        wr_addr_q.delete();
        st_q.delete();
        st_cyc_q.delete();
        overlap = 0;
        blk_cnt = 0;
    endtask

    task automatic start_run(input int n, input int bm, input int rm);
        logic [31:0] r;
        for (int k = 0; k < n && (BLK + BLK*k + BLK - 1) < SIZE; k++)
            for (int i = 0; i < BLK; i++) begin
                r = $urandom;
                mem[BLK + BLK*k + i]  = r;
                orig[BLK + BLK*k + i] = r;
            end
        clear_logs();
        blk_mode = bm;
        res_mode = rm;
        r = $urandom;
        r[15:8] = 8'(n);
        r[0] = 1'b0;
        cfg_word = r;
        repeat (2) @(negedge clk);
        cfg_word[0] = 1'b1;
        cfg_cyc = cyc;
    endtask

    task automatic wait_done(input int bound, output bit ok);
        logic [CW-1:0] last;
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk);
            if (st_q.size() > 0) begin
                last = st_q[st_q.size()-1];
                if (last[1]) ok = 1'b1;
            end
        end
    endtask

    task automatic finish_run(input int n, input bit lat);
        bit            ok;
        bit            in_range;
        int            exp_rd;
        int            a;
        logic [CW-1:0] exp_st[$];
        logic [W-1:0]  ge, gg;
        wait_done(80 * (n + 1) + 100, ok);
        check_eq("done_seen", W'(ok), W'(1));
        repeat (2) @(negedge clk);
        in_range = (BLK * (n + 1) <= SIZE);
        if (in_range) begin
            exp_st.push_back(mk_status(0, 1, 0, 0));
            for (int k = 0; k < n; k++) exp_st.push_back(mk_status(k + 1, 1, 0, 0));
            exp_st.push_back(mk_status(n, 0, 1, 0));
            exp_rd = n;
        end else begin
            exp_st.push_back(mk_status(0, 0, 1, 1));
            exp_rd = 0;
        end
        check_eq("status_count", W'(st_q.size()), W'(exp_st.size()));
        for (int i = 0; i < exp_st.size() && i < st_q.size(); i++)
            check_eq("status_seq", W'(st_q[i]), W'(exp_st[i]));
        check_eq("rd_count", W'(rd_addr_q.size()), W'(exp_rd));
        check_eq("wr_count", W'(wr_addr_q.size()), W'(exp_rd));
        for (int k = 0; k < exp_rd && k < rd_addr_q.size(); k++)
            check_eq("rd_addr", W'(rd_addr_q[k]), W'(BLK + BLK*k));
        for (int k = 0; k < exp_rd && k < wr_addr_q.size(); k++)
            check_eq("wr_addr", W'(wr_addr_q[k]), W'(BLK + BLK*k));
        for (int k = 0; k < exp_rd; k++) begin
            a = BLK + BLK*k;
            for (int i = 0; i < BLK; i++) begin
                ge[i*CW +: CW] = orig[a + i] + 32'd1;
                gg[i*CW +: CW] = mem[a + i];
            end
            check_eq("wb_data", gg, ge);
        end
        check_eq("status_word", W'(mem[1]), W'(exp_st[exp_st.size()-1]));
        check_eq("rd_wr_overlap", W'(overlap), W'(0));
        check_eq("blk_count", W'(blk_cnt), W'(exp_rd));
        if (lat && exp_rd > 0 && rd_cyc_q.size() > 0)
            check_eq("start_latency", W'(rd_cyc_q[0] - cfg_cyc), W'(2));
        if (lat && exp_rd > 1 && rd_cyc_q.size() > 1)
            check_eq("block_latency", W'(rd_cyc_q[1] - rd_cyc_q[0]), W'(5));
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_strobes"}, W'({read_en, write_en, status_en, blk_valid, res_ready}), W'(0));
        check_eq({tag, "_address"}, W'(address), W'(0));
        check_eq({tag, "_data"}, wdata | blk_data, W'(0));
        check_eq({tag, "_status"}, W'(status), W'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "global timeout");
    end

    initial begin
        bit   ok;
        bit   found;
        logic [W-1:0] exp_op;
        int   n;

        for (int i = 0; i < SIZE; i++) begin
            mem[i]  = '0;
            orig[i] = '0;
        end
        rst = 1'b1;
        cfg_word = '0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // N=2, compute always ready: addresses, write-back, status sequence, latencies
        start_run(2, 0, 0);
        finish_run(2, 1'b1);

        // Level held high after completion must not retrigger
        clear_logs();
        repeat (30) @(negedge clk);
        check_eq("hold_no_status", W'(st_q.size()), W'(0));
        check_eq("hold_no_read", W'(rd_addr_q.size()), W'(0));

        // Toggling start re-runs the sequence
        start_run(2, 0, 0);
        finish_run(2, 1'b1);

        // N=0: busy then done, no data traffic
        start_run(0, 0, 0);
        finish_run(0, 1'b0);

        // Operand stall: valid/data must hold while ready is low
        start_run(2, 2, 0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            found = blk_valid;
        end
        check_eq("stall_valid_seen", W'(found), W'(1));
        for (int i = 0; i < BLK; i++) exp_op[i*CW +: CW] = orig[BLK + i];
        for (int c = 0; c < 10; c++) begin
            check_eq("stall_valid", W'(blk_valid), W'(1));
            check_eq("stall_data", blk_data, exp_op);
            @(negedge clk);
        end
        check_eq("stall_no_transfer", W'(blk_cnt), W'(0));
        blk_mode = 0;
        finish_run(2, 1'b0);

        // Randomised runs with random compute back-pressure
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(0, 7);
            start_run(n, 1, 1);
            finish_run(n, 1'b0);
        end

        // Range boundary: 63 fits exactly, 64 and 255 overflow
        start_run(63, 1, 1);
        finish_run(63, 1'b0);
        start_run(64, 0, 0);
        finish_run(64, 1'b0);
        start_run(255, 0, 0);
        finish_run(255, 1'b0);

        // Reset while waiting for block 0 result
        start_run(2, 0, 2);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            found = res_ready;
        end
        check_eq("rst_result_seen", W'(found), W'(1));
        #2 rst = 1'b1;
        #1 check_outputs_zero("midrun_reset");
        cfg_word = '0;
        res_pend.delete();
        res_mode = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check_eq("rst_no_write", W'(wr_addr_q.size()), W'(0));
        check_eq("rst_single_read", W'(rd_addr_q.size()), W'(1));
        check_eq("rst_status_only_busy", W'(st_q.size()), W'(1));
        for (int i = 0; i < BLK; i++) check_eq("rst_mem_intact", W'(mem[BLK + i]), W'(orig[BLK + i]));
        check_outputs_zero("post_reset_idle");

`ifdef SEQ_TIMEOUT_EN
        // Result never arrives: watchdog ends the run with an error status
        start_run(2, 0, 2);
        wait_done(200, ok);
        check_eq("tmo_seen", W'(ok), W'(1));
        if (st_q.size() > 0) begin
            check_eq("tmo_status", W'(st_q[st_q.size()-1]), W'(32'h006));
            check_eq("tmo_delay", W'(st_cyc_q[st_cyc_q.size()-1] - res_entry_cyc), W'(TMO));
        end
        check_eq("tmo_no_write", W'(wr_addr_q.size()), W'(0));
        res_pend.delete();
        res_mode = 0;
        repeat (3) @(negedge clk);
`endif

        // Normal operation after the abort
        start_run(3, 1, 1);
        finish_run(3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
